// File: rtl/rf_writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback requesters, with pending-write scoreboard (RF_WB_BYPASS_EN adds same-cycle bypass).
// Latency: accept at edge N -> rf_ld/rf_addr/rf_data valid during cycle N+1, commit at edge N+1.
// Backpressure: output stage never stalls; one valid requester granted per cycle, so each waits at most NREQ cycles.
module rf_writeback_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input  logic                 Clk,
  input  logic                 Clr,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  input  logic [AW-1:0]        rd_sel1,
  input  logic [AW-1:0]        rd_sel2,
  input  logic [DW-1:0]        rd_q1,
  input  logic [DW-1:0]        rd_q2,
  output logic                 rf_ld,
  output logic [AW-1:0]        rf_addr,
  output logic [DW-1:0]        rf_data,
  output logic [DW-1:0]        byp_q1,
  output logic [DW-1:0]        byp_q2,
  output logic [(1<<AW)-1:0]   busy_mask,
  output logic                 stall,
  output logic                 wb_err
);

  localparam int NR = 1 << AW;
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_nxt;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  logic          gnt_any;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [NR-1:0] set_vec;
  logic [NR-1:0] clr_vec;
  logic          hit1;
  logic          hit2;

  // First valid requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    gnt_idx   = '0;
    gnt_any   = 1'b0;
    cand      = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_addr = req_addr[k*AW +: AW];
        sel_data = req_data[k*DW +: DW];
      end
    end
    rr_nxt = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      rr_ptr  <= '0;
      rf_ld   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      wb_err  <= 1'b0;
    end else begin
      rf_ld <= gnt_any;
      if (gnt_any) begin
        rr_ptr  <= rr_nxt;
        rf_addr <= sel_addr;
        rf_data <= sel_data;
        if (!busy_mask[sel_addr]) wb_err <= 1'b1;
      end
    end
  end

  // Set is applied after clear so a same-edge re-reservation keeps the bit.
  assign set_vec = alloc_en ? (NR'(1) << alloc_addr) : '0;
  assign clr_vec = rf_ld    ? (NR'(1) << rf_addr)    : '0;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) busy_mask <= '0;
    else      busy_mask <= (busy_mask & ~clr_vec) | set_vec;
  end

`ifdef RF_WB_BYPASS_EN
  assign hit1   = rf_ld && (rf_addr == rd_sel1);
  assign hit2   = rf_ld && (rf_addr == rd_sel2);
  assign byp_q1 = hit1 ? rf_data : rd_q1;
  assign byp_q2 = hit2 ? rf_data : rd_q2;
`else
  assign hit1   = 1'b0;
  assign hit2   = 1'b0;
  assign byp_q1 = rd_q1;
  assign byp_q2 = rd_q2;
`endif

  assign stall = (busy_mask[rd_sel1] & ~hit1) | (busy_mask[rd_sel2] & ~hit2);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: scenario tasks with a write scoreboard queue.
module tb_rf_writeback_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic              Clk;
  logic              Clr;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic [AW-1:0]     rd_sel1, rd_sel2;
  logic [DW-1:0]     rd_q1, rd_q2;
  logic              rf_ld;
  logic [AW-1:0]     rf_addr;
  logic [DW-1:0]     rf_data;
  logic [DW-1:0]     byp_q1, byp_q2;
  logic [15:0]       busy_mask;
  logic              stall;
  logic              wb_err;

  int vectors = 0;
  int miscompares = 0;
  wr_t sb_q[$];
  wr_t exp_w;

  rf_writeback_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Clr(Clr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_q1(rd_q1), .rd_q2(rd_q2),
    .rf_ld(rf_ld), .rf_addr(rf_addr), .rf_data(rf_data),
    .byp_q1(byp_q1), .byp_q2(byp_q2),
    .busy_mask(busy_mask), .stall(stall), .wb_err(wb_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_dut();
    Clr = 1'b0;
    req_valid = '0; alloc_en = 1'b0; alloc_addr = '0;
    req_addr = '0; req_data = '0;
    rd_sel1 = '0; rd_sel2 = '0; rd_q1 = '0; rd_q2 = '0;
    sb_q.delete();
    step();
    Clr = 1'b1;
  endtask

  task automatic alloc_one(input logic [AW-1:0] r);
    alloc_en = 1'b1; alloc_addr = r;
    step();
    alloc_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    Clr = 1'b0;
    #1;
    vectors++;
    if ({rf_ld, rf_addr, rf_data, busy_mask, wb_err, req_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rf_ld=%b addr=%h data=%h busy=%h err=%b rdy=%b, want all 0",
               rf_ld, rf_addr, rf_data, busy_mask, wb_err, req_ready);
    end
    Clr = 1'b1;
    alloc_one(4'd3);
    req_valid = 3'b001; req_addr = {4'd0, 4'd0, 4'd3}; req_data = {32'd0, 32'd0, 32'hDEADBEEF};
    step();
    req_valid = '0;
    vectors++;
    if (rf_ld !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_prewrite_ld: got %b want 1", rf_ld);
    end
    #2 Clr = 1'b0;
    #1;
    vectors++;
    if ({rf_ld, rf_addr, rf_data, busy_mask, wb_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_midwrite: rf_ld=%b addr=%h data=%h busy=%h err=%b, want all 0",
               rf_ld, rf_addr, rf_data, busy_mask, wb_err);
    end
    step();
    vectors++;
    if (rf_ld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held_ld: got %b want 0", rf_ld);
    end
    Clr = 1'b1;
  endtask

  task automatic test_single_write();
    reset_dut();
    alloc_one(4'd5);
    vectors++;
    if (busy_mask !== 16'h0020) begin
      miscompares++;
      $display("FAIL single_alloc_busy: got %h want 0020", busy_mask);
    end
    req_valid = 3'b001; req_addr = {4'd0, 4'd0, 4'd5}; req_data = {32'd0, 32'd0, 32'h0000B00B};
    #1;
    vectors++;
    if (req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 001", req_ready);
    end
    sb_q.push_back('{a: 4'd5, d: 32'h0000B00B});
    step();
    req_valid = '0;
    exp_w = sb_q.pop_front();
    vectors++;
    if (rf_ld !== 1'b1 || rf_addr !== exp_w.a || rf_data !== exp_w.d) begin
      miscompares++;
      $display("FAIL single_out: ld=%b addr=%h data=%h want 1 %h %h", rf_ld, rf_addr, rf_data, exp_w.a, exp_w.d);
    end
    vectors++;
    if (busy_mask[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_busy_during: got %b want 1", busy_mask[5]);
    end
    step();
    vectors++;
    if (rf_ld !== 1'b0 || busy_mask !== 16'h0 || rf_addr !== 4'd5 || rf_data !== 32'h0000B00B || wb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after: ld=%b busy=%h addr=%h data=%h err=%b want 0 0000 5 0000b00b 0",
               rf_ld, busy_mask, rf_addr, rf_data, wb_err);
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_rdy;
    int order[2];
    reset_dut();
    alloc_one(4'd1); alloc_one(4'd2); alloc_one(4'd3);
    req_valid = 3'b111;
    req_addr = {4'd3, 4'd2, 4'd1};
    req_data = {32'hC0000003, 32'hB0000002, 32'hA0000001};
    for (int g = 0; g < 3; g++) begin
      #1;
      exp_rdy = 3'b001 << g;
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL contention_grant%0d: got %b want %b", g, req_ready, exp_rdy);
      end
      sb_q.push_back('{a: req_addr[g*AW +: AW], d: req_data[g*DW +: DW]});
      step();
      req_valid[g] = 1'b0;
      exp_w = sb_q.pop_front();
      vectors++;
      if (rf_ld !== 1'b1 || rf_addr !== exp_w.a || rf_data !== exp_w.d) begin
        miscompares++;
        $display("FAIL contention_out%0d: ld=%b addr=%h data=%h want 1 %h %h", g, rf_ld, rf_addr, rf_data, exp_w.a, exp_w.d);
      end
    end
    alloc_one(4'd4); alloc_one(4'd6);
    req_valid = 3'b101;
    req_addr = {4'd6, 4'd0, 4'd4};
    req_data = {32'h66666666, 32'h0, 32'h44444444};
    order[0] = 0; order[1] = 2;
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_rdy = 3'b001 << order[i];
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL revalid_grant%0d: got %b want %b", i, req_ready, exp_rdy);
      end
      sb_q.push_back('{a: req_addr[order[i]*AW +: AW], d: req_data[order[i]*DW +: DW]});
      step();
      req_valid[order[i]] = 1'b0;
      exp_w = sb_q.pop_front();
      vectors++;
      if (rf_ld !== 1'b1 || rf_addr !== exp_w.a || rf_data !== exp_w.d) begin
        miscompares++;
        $display("FAIL revalid_out%0d: ld=%b addr=%h data=%h want 1 %h %h", i, rf_ld, rf_addr, rf_data, exp_w.a, exp_w.d);
      end
    end
    step();
    vectors++;
    if (wb_err !== 1'b0 || busy_mask !== 16'h0) begin
      miscompares++;
      $display("FAIL contention_end: err=%b busy=%h want 0 0000", wb_err, busy_mask);
    end
  endtask

  task automatic test_set_clear();
    reset_dut();
    alloc_one(4'd7);
    req_valid = 3'b001; req_addr = {4'd0, 4'd0, 4'd7}; req_data = {32'd0, 32'd0, 32'h77777777};
    step();
    req_valid = '0;
    alloc_en = 1'b1; alloc_addr = 4'd7;
    vectors++;
    if (rf_ld !== 1'b1 || rf_addr !== 4'd7) begin
      miscompares++;
      $display("FAIL setclr_write: ld=%b addr=%h want 1 7", rf_ld, rf_addr);
    end
    step();
    alloc_en = 1'b0;
    vectors++;
    if (busy_mask !== 16'h0080) begin
      miscompares++;
      $display("FAIL setclr_busy7: got %h want 0080", busy_mask);
    end
  endtask

  task automatic test_hazard();
    reset_dut();
    alloc_one(4'd5);
    rd_sel1 = 4'd5; rd_sel2 = 4'd0; rd_q1 = 32'h11111111; rd_q2 = 32'h22222222;
    #1;
    vectors++;
    if (stall !== 1'b1 || byp_q1 !== 32'h11111111 || byp_q2 !== 32'h22222222) begin
      miscompares++;
      $display("FAIL hazard_pending: stall=%b q1=%h q2=%h want 1 11111111 22222222", stall, byp_q1, byp_q2);
    end
    req_valid = 3'b001; req_addr = {4'd0, 4'd0, 4'd5}; req_data = {32'd0, 32'd0, 32'h0000CAFE};
    step();
    req_valid = '0;
`ifdef RF_WB_BYPASS_EN
    vectors++;
    if (stall !== 1'b0 || byp_q1 !== 32'h0000CAFE || byp_q2 !== 32'h22222222) begin
      miscompares++;
      $display("FAIL hazard_commit: stall=%b q1=%h q2=%h want 0 0000cafe 22222222", stall, byp_q1, byp_q2);
    end
`else
    vectors++;
    if (stall !== 1'b1 || byp_q1 !== 32'h11111111 || byp_q2 !== 32'h22222222) begin
      miscompares++;
      $display("FAIL hazard_commit: stall=%b q1=%h q2=%h want 1 11111111 22222222", stall, byp_q1, byp_q2);
    end
`endif
    step();
    vectors++;
    if (stall !== 1'b0 || byp_q1 !== 32'h11111111) begin
      miscompares++;
      $display("FAIL hazard_after: stall=%b q1=%h want 0 11111111", stall, byp_q1);
    end
    rd_sel1 = '0;
  endtask

  task automatic test_error();
    reset_dut();
    req_valid = 3'b010; req_addr = {4'd0, 4'd9, 4'd0}; req_data = {32'd0, 32'h99999999, 32'd0};
    #1;
    vectors++;
    if (req_ready !== 3'b010 || wb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL error_grant: rdy=%b err=%b want 010 0", req_ready, wb_err);
    end
    sb_q.push_back('{a: 4'd9, d: 32'h99999999});
    step();
    req_valid = '0;
    exp_w = sb_q.pop_front();
    vectors++;
    if (rf_ld !== 1'b1 || rf_addr !== exp_w.a || rf_data !== exp_w.d || wb_err !== 1'b1) begin
      miscompares++;
      $display("FAIL error_write: ld=%b addr=%h data=%h err=%b want 1 %h %h 1", rf_ld, rf_addr, rf_data, wb_err, exp_w.a, exp_w.d);
    end
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (wb_err !== 1'b1) begin
      miscompares++;
      $display("FAIL error_sticky: got %b want 1", wb_err);
    end
    Clr = 1'b0;
    #1;
    vectors++;
    if (wb_err !== 1'b0) begin
      miscompares++;
      $display("FAIL error_clr: got %b want 0", wb_err);
    end
    Clr = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_set_clear();
    test_hazard();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
